// File: rtl/aes_sbox_pipe.sv
// Pipelined AES SubBytes / InvSubBytes engine: NUM_BYTES lanes, each with one
// shared GF(2^8) inverter, valid/ready streaming with full backpressure.

module aes_sbox_front (
  input  logic [7:0] x,
  input  logic       inverse,
  output logic [7:0] y
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 by a fixed addition chain; maps 0 to 0 without a special case
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
    a15  = gf_mul(a12, a3);
    a240 = gf_mul(a15, a15);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    a240 = gf_mul(a240, a240);
    return gf_mul(gf_mul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] s);
    logic [7:0] b;
    for (int i = 0; i < 8; i++)
      b[i] = s[(i+2)%8] ^ s[(i+5)%8] ^ s[(i+7)%8];
    return b ^ 8'h05;
  endfunction

  assign y = gf_inv(inverse ? aff_inv(x) : x);
endmodule

module aes_sbox_back (
  input  logic [7:0] y,
  input  logic       inverse,
  output logic [7:0] z
);
  function automatic logic [7:0] aff(input logic [7:0] b);
    logic [7:0] s;
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8];
    return s ^ 8'h63;
  endfunction

  assign z = inverse ? y : aff(y);
endmodule

module aes_sbox_pipe #(
  parameter int NUM_BYTES = 4,
  parameter int STAGES    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_inverse,
  input  logic [8*NUM_BYTES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_inverse,
  output logic [8*NUM_BYTES-1:0] out_data
);
  logic [NUM_BYTES-1:0][7:0] lane_in, lane_inv, back_in, lane_out;
  logic                      back_mode;
  logic                      adv1;
  logic                      s1_vld, s1_inv;
  logic [NUM_BYTES-1:0][7:0] s1_dat;

  if (NUM_BYTES < 1 || NUM_BYTES > 16) begin : g_bad_lanes
    $fatal(1, "aes_sbox_pipe: NUM_BYTES must be 1..16");
  end

  assign lane_in  = in_data;
  // reset forces acceptance-ready even when the stages are still full
  assign in_ready = reset | adv1;

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_lane
    aes_sbox_front u_front (.x(lane_in[i]), .inverse(in_inverse), .y(lane_inv[i]));
    aes_sbox_back  u_back  (.y(back_in[i]), .inverse(back_mode),  .z(lane_out[i]));
  end

  if (STAGES == 1) begin : g_one
    assign back_in   = lane_inv;
    assign back_mode = in_inverse;
    assign adv1      = !s1_vld || out_ready;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_vld <= 1'b0;
        s1_inv <= 1'b0;
        s1_dat <= '0;
      end else if (adv1) begin
        s1_vld <= in_valid;
        if (in_valid) begin
          s1_inv <= in_inverse;
          s1_dat <= lane_out;
        end
      end
    end

    assign out_valid   = s1_vld;
    assign out_inverse = s1_inv;
    assign out_data    = s1_dat;
  end else if (STAGES == 2) begin : g_two
    logic                      s2_vld, s2_inv, adv2;
    logic [NUM_BYTES-1:0][7:0] s2_dat;

    // stage 1 holds raw inverter output; the output affine runs after it
    assign back_in   = s1_dat;
    assign back_mode = s1_inv;
    assign adv2      = !s2_vld || out_ready;
    assign adv1      = !s1_vld || adv2;

    always_ff @(posedge clk) begin
      if (reset) begin
        s1_vld <= 1'b0;
        s1_inv <= 1'b0;
        s1_dat <= '0;
        s2_vld <= 1'b0;
        s2_inv <= 1'b0;
        s2_dat <= '0;
      end else begin
        if (adv1) begin
          s1_vld <= in_valid;
          if (in_valid) begin
            s1_inv <= in_inverse;
            s1_dat <= lane_inv;
          end
        end
        if (adv2) begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_inv <= s1_inv;
            s2_dat <= lane_out;
          end
        end
      end
    end

    assign out_valid   = s2_vld;
    assign out_inverse = s2_inv;
    assign out_data    = s2_dat;
  end else begin : g_bad_stages
    $fatal(1, "aes_sbox_pipe: STAGES must be 1 or 2");
  end
endmodule
